banked_ram: RTL and testbench
=============================

BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, data RAM size in 32-bit words, power of two, minimum 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0, aligned to 4*DEPTH.
REQ-003 SHALL have parameter READ_PIPE, default 0, adding one output register stage to read latency when 1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, 1, request present.
REQ-007 SHALL have port req_ready_o, output, 1, request accepted this cycle when high with req_valid_i.
REQ-008 SHALL have port req_addr_i, input, 32, byte address.
REQ-009 SHALL have port req_we_i, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port req_size_i, input, 3, size: 000 byte, 001 half, 010 word, 011 byte unsigned, 100 half unsigned.
REQ-011 SHALL have port req_wdata_i, input, 32, store data, LSB-justified.
REQ-012 SHALL have port resp_valid_o, output, 1, response present.
REQ-013 SHALL have port resp_ready_i, input, 1, consumer takes response.
REQ-014 SHALL have port resp_rdata_o, output, 32, load data, extended to 32 bits.
REQ-015 SHALL have port resp_err_o, output, 2, 00 ok, 01 misaligned, 10 out of range, 11 illegal size.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid_i and req_ready_o are both high ("accept edge" T).
REQ-017 SHALL use a state machine with states IDLE, WAIT (READ_PIPE=1 only) and RESP; it SHALL leave reset in IDLE.
REQ-018 SHALL drive req_ready_o = (state==IDLE) or (state==RESP and resp_ready_i), forced 0 while rst high.
REQ-019 SHALL on acceptance go to RESP when READ_PIPE=0, or to WAIT then RESP one cycle later when READ_PIPE=1.
REQ-020 SHALL assert resp_valid_o only in RESP and hold rdata/err stable until the edge where resp_ready_i is high.
REQ-021 SHALL, on a response handshake without a new acceptance, return to IDLE.
REQ-022 SHALL, on a response handshake with a same-edge acceptance, go to RESP or WAIT per REQ-019 (back-to-back, one access per cycle when READ_PIPE=0).
REQ-023 SHALL classify errors with priority: size 101/110/111, or store with size 011/100 -> 11; else half with addr[0]=1 or word with addr[1:0]!=0 -> 01; else address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) -> 10.
REQ-024 SHALL, on an errored request, leave memory unchanged and return resp_rdata_o = 0 with the error code.
REQ-025 SHALL commit a legal store at the accept edge: byte -> wdata[7:0] to lane addr[1:0]; half -> wdata[15:0] to lanes {addr[1],0}/{addr[1],1}; word -> all four lanes; other lanes untouched.
REQ-026 SHALL return resp_rdata_o = 0 and resp_err_o = 00 for a legal store.
REQ-027 SHALL sample a legal load at the accept edge: byte/half sign-extended (000/001) or zero-extended (011/100) from the addressed lane, word unchanged.
REQ-028 SHALL return, for a load accepted one edge after a store to the same word, the post-store contents.
REQ-029 SHALL index memory with (addr - BASE_ADDR)[log2(DEPTH)+1:2].

Reset
REQ-030 SHALL, while rst high at an edge, set state IDLE, resp_valid_o 0, resp_rdata_o 0, resp_err_o 00.
REQ-031 SHALL discard any pending WAIT/RESP response on reset, without undoing stores already committed.
REQ-032 SHALL NOT reset or initialise memory contents, and SHALL not accept requests during reset.

Verification
REQ-033 SHALL be verified by: sw 0x8765_4321 to 0x10, then lw 0x10 -> rdata 0x8765_4321, err 00, resp_valid one edge after accept (READ_PIPE=0), two (READ_PIPE=1).
REQ-034 SHALL be verified by: sb 0xAB to 0x13 over word 0, then lb 0x13 -> 0xFFFF_FFAB; lbu 0x13 -> 0x0000_00AB; lw 0x10 -> 0xAB65_4321.
REQ-035 SHALL be verified by: sh to 0x11 -> err 01; lw 0x12 -> err 01; lw BASE_ADDR+4*DEPTH -> err 10; size 101 -> err 11; store size 011 -> err 11; memory unchanged in all five.
REQ-036 SHALL be verified by: resp_ready_i held low 3 cycles -> resp_valid_o, rdata, err stable, req_ready_o 0; releasing with req_valid_i high -> back-to-back acceptance same edge.
REQ-037 SHALL be verified by: rst pulsed in RESP after a store -> resp_valid_o 0 next edge, state IDLE, later load returns stored value.
REQ-038 SHALL be verified by: continuous alternating sw/lw stream with resp_ready_i=1, READ_PIPE=0 -> one response per cycle, all data correct.

Source files
------------

// File: rtl/banked_ram_if.sv
// Request/response bus between a load/store client and banked_ram.
interface banked_ram_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/banked_ram.sv
// Single-port byte-lane word RAM with a valid/ready request and response channel.
// Stores commit and loads sample at the accept edge; READ_PIPE adds one stage.
module banked_ram #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_PIPE = 0
) (
  input logic         clk,
  input logic         rst,
  banked_ram_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam state_e ACC_NEXT = (READ_PIPE != 0) ? WAIT : RESP;

  state_e        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic          accept_c;
  logic [31:0]   off_c;
  logic [AW-1:0] idx_c;
  logic          in_range_c;
  logic [1:0]    err_c;
  logic [31:0]   rword_c, rshift_c, load_c, rsp_data_c, wshift_c;
  logic [3:0]    be_c;
  logic          resp_valid_q;
  logic [31:0]   resp_rdata_q, pipe_rdata_q;
  logic [1:0]    resp_err_q, pipe_err_q;

  assign bus.req_ready_o  = !rst && ((state_q == IDLE) || ((state_q == RESP) && bus.resp_ready_i));
  assign accept_c         = bus.req_valid_i && bus.req_ready_o;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;

  // Word index relative to the base; an address below the base wraps high and fails the range test.
  assign off_c      = bus.req_addr_i - BASE_ADDR;
  assign idx_c      = off_c[AW+1:2];
  assign in_range_c = ({1'b0, off_c} < SPAN);

  // Error classification in priority order: illegal size, misalignment, range.
  always_comb begin
    err_c = 2'b00;
    if ((bus.req_size_i > 3'd4) ||
        (bus.req_we_i && ((bus.req_size_i == 3'd3) || (bus.req_size_i == 3'd4)))) begin
      err_c = 2'b11;
    end else if ((((bus.req_size_i == 3'd1) || (bus.req_size_i == 3'd4)) && bus.req_addr_i[0]) ||
                 ((bus.req_size_i == 3'd2) && (bus.req_addr_i[1:0] != 2'b00))) begin
      err_c = 2'b01;
    end else if (!in_range_c) begin
      err_c = 2'b10;
    end
  end

  // Load lane extraction and extension; stores and errors answer with zero.
  always_comb begin
    rword_c  = mem[idx_c];
    rshift_c = rword_c >> {bus.req_addr_i[1:0], 3'b000};
    case (bus.req_size_i)
      3'd0:    load_c = {{24{rshift_c[7]}}, rshift_c[7:0]};
      3'd1:    load_c = {{16{rshift_c[15]}}, rshift_c[15:0]};
      3'd3:    load_c = {24'd0, rshift_c[7:0]};
      3'd4:    load_c = {16'd0, rshift_c[15:0]};
      default: load_c = rword_c;
    endcase
    rsp_data_c = (bus.req_we_i || (err_c != 2'b00)) ? 32'd0 : load_c;
  end

  // Byte enables for a legal accepted store, with data moved onto its lanes.
  always_comb begin
    wshift_c = bus.req_wdata_i << {bus.req_addr_i[1:0], 3'b000};
    case (bus.req_size_i)
      3'd0:    be_c = 4'b0001 << bus.req_addr_i[1:0];
      3'd1:    be_c = 4'b0011 << {bus.req_addr_i[1], 1'b0};
      3'd2:    be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
    if (!(accept_c && bus.req_we_i && (err_c == 2'b00))) be_c = 4'b0000;
  end

  // Memory array write; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) mem[idx_c][8*i +: 8] <= wshift_c[8*i +: 8];
    end
  end

  // Next-state logic for the request/response sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ACC_NEXT;
      WAIT:    state_d = RESP;
      RESP:    if (bus.resp_ready_i) state_d = accept_c ? ACC_NEXT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; response payload holds until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'b00;
      pipe_rdata_q <= 32'd0;
      pipe_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_d == RESP);
      if (accept_c) begin
        pipe_rdata_q <= rsp_data_c;
        pipe_err_q   <= err_c;
      end
      if ((READ_PIPE == 0) && accept_c) begin
        resp_rdata_q <= rsp_data_c;
        resp_err_q   <= err_c;
      end else if ((READ_PIPE != 0) && (state_q == WAIT)) begin
        resp_rdata_q <= pipe_rdata_q;
        resp_err_q   <= pipe_err_q;
      end
    end
  end
endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram: one unpipelined and one pipelined, offset instance.
module tb_banked_ram;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  banked_ram_if b0 ();
  banked_ram_if b1 ();

  banked_ram #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .READ_PIPE(0)) u_ram0 (
    .clk (clk), .rst (rst), .bus (b0)
  );
  banked_ram #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .READ_PIPE(1)) u_ram1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? b0.req_ready_o : b1.req_ready_o;
  endfunction

  function automatic logic vld(input int which);
    return (which == 0) ? b0.resp_valid_o : b1.resp_valid_o;
  endfunction

  task automatic set_req(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd);
    b0.req_we_i = we; b0.req_size_i = sz; b0.req_addr_i = addr; b0.req_wdata_i = wd;
    b1.req_we_i = we; b1.req_size_i = sz; b1.req_addr_i = addr; b1.req_wdata_i = wd;
  endtask

  // One full request/response exchange with response always accepted.
  task automatic op(input string tag, input int which, input logic we, input logic [2:0] sz,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic [1:0] exp_er, input int exp_lat);
    int lat;
    set_req(we, sz, addr, wd);
    b0.resp_ready_i = 1'b1;
    b1.resp_ready_i = 1'b1;
    if (which == 0) b0.req_valid_i = 1'b1;
    else            b1.req_valid_i = 1'b1;
    chk({tag, "_acc"}, 32'(rdy(which)), 32'd1);
    @(posedge clk); #1;
    b0.req_valid_i = 1'b0;
    b1.req_valid_i = 1'b0;
    lat = 1;
    while (!vld(which) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rd"}, (which == 0) ? b0.resp_rdata_o : b1.resp_rdata_o, exp_rd);
    chk({tag, "_err"}, 32'((which == 0) ? b0.resp_err_o : b1.resp_err_o), 32'(exp_er));
    @(posedge clk); #1;
  endtask

  logic [31:0] s_addr [8];
  logic [31:0] s_data [8];
  logic        s_we   [8];
  logic [31:0] s_exp  [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0.req_valid_i = 1'b0; b1.req_valid_i = 1'b0;
    b0.resp_ready_i = 1'b1; b1.resp_ready_i = 1'b1;
    set_req(1'b0, 3'd2, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(b0.req_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_vld", 32'(b0.resp_valid_o), 32'd0);
    chk("rst_rd", b0.resp_rdata_o, 32'd0);
    chk("rst_err", 32'(b0.resp_err_o), 32'd0);
    chk("idle_ready", 32'(b0.req_ready_o), 32'd1);

    // Basic word store/load and byte/half extension.
    op("sw10",   0, 1'b1, 3'd2, 32'h10, 32'h8765_4321, 32'h0, 2'b00, 1);
    op("lw10",   0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h8765_4321, 2'b00, 1);
    op("sb13",   0, 1'b1, 3'd0, 32'h13, 32'h0000_00AB, 32'h0, 2'b00, 1);
    op("lb13",   0, 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFF_FFAB, 2'b00, 1);
    op("lbu13",  0, 1'b0, 3'd3, 32'h13, 32'h0, 32'h0000_00AB, 2'b00, 1);
    op("lw10b",  0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hAB65_4321, 2'b00, 1);
    op("lh12",   0, 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_AB65, 2'b00, 1);
    op("lhu10",  0, 1'b0, 3'd4, 32'h10, 32'h0, 32'h0000_4321, 2'b00, 1);
    op("sw00",   0, 1'b1, 3'd2, 32'h00, 32'h0000_0000, 32'h0, 2'b00, 1);

    // Error classes, each leaving memory untouched.
    op("sh11",   0, 1'b1, 3'd1, 32'h11, 32'h0000_FFFF, 32'h0, 2'b01, 1);
    op("lw12",   0, 1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 2'b01, 1);
    op("lw40",   0, 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 2'b10, 1);
    op("sw40",   0, 1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, 32'h0, 2'b10, 1);
    op("ld101",  0, 1'b0, 3'd5, 32'h10, 32'h0, 32'h0, 2'b11, 1);
    op("st011",  0, 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, 32'h0, 2'b11, 1);
    op("lw10c",  0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hAB65_4321, 2'b00, 1);
    op("lw00",   0, 1'b0, 3'd2, 32'h00, 32'h0, 32'h0000_0000, 2'b00, 1);
    op("sh12",   0, 1'b1, 3'd1, 32'h12, 32'h0000_1234, 32'h0, 2'b00, 1);
    op("lw10d",  0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h1234_4321, 2'b00, 1);

    // Response backpressure, then release with a waiting request.
    set_req(1'b0, 3'd2, 32'h10, 32'h0);
    b0.resp_ready_i = 1'b0;
    b0.req_valid_i  = 1'b1;
    @(posedge clk); #1;
    set_req(1'b1, 3'd2, 32'h14, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      chk("bp_vld", 32'(b0.resp_valid_o), 32'd1);
      chk("bp_rd", b0.resp_rdata_o, 32'h1234_4321);
      chk("bp_err", 32'(b0.resp_err_o), 32'd0);
      chk("bp_ready", 32'(b0.req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    b0.resp_ready_i = 1'b1;
    #1;
    chk("rel_ready", 32'(b0.req_ready_o), 32'd1);
    @(posedge clk); #1;
    chk("b2b_vld", 32'(b0.resp_valid_o), 32'd1);
    chk("b2b_rd", b0.resp_rdata_o, 32'd0);
    b0.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done", 32'(b0.resp_valid_o), 32'd0);
    op("lw14",   0, 1'b0, 3'd2, 32'h14, 32'h0, 32'hCAFE_F00D, 2'b00, 1);

    // Reset while a store response is pending.
    set_req(1'b1, 3'd2, 32'h18, 32'h1122_3344);
    b0.resp_ready_i = 1'b0;
    b0.req_valid_i  = 1'b1;
    @(posedge clk); #1;
    b0.req_valid_i = 1'b0;
    chk("pre_rst_vld", 32'(b0.resp_valid_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld", 32'(b0.resp_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(b0.req_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 32'(b0.req_ready_o), 32'd1);
    op("lw18",   0, 1'b0, 3'd2, 32'h18, 32'h0, 32'h1122_3344, 2'b00, 1);

    // Alternating store/load stream, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 32'h20 + 32'(4 * (i / 2));
      s_data[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
      s_we[i]   = (i % 2) == 0;
    end
    for (int i = 0; i < 8; i++) s_exp[i] = s_we[i] ? 32'd0 : s_data[i-1];
    b0.resp_ready_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        set_req(s_we[i], 3'd2, s_addr[i], s_data[i]);
        b0.req_valid_i = 1'b1;
        chk("st_ready", 32'(b0.req_ready_o), 32'd1);
      end else begin
        b0.req_valid_i = 1'b0;
      end
      if (i > 0) begin
        chk("st_vld", 32'(b0.resp_valid_o), 32'd1);
        chk("st_rd", b0.resp_rdata_o, s_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    chk("st_end", 32'(b0.resp_valid_o), 32'd0);

    // Pipelined instance with a non-zero base address.
    op("p_sw",   1, 1'b1, 3'd2, 32'h1010, 32'h8765_4321, 32'h0, 2'b00, 2);
    op("p_lw",   1, 1'b0, 3'd2, 32'h1010, 32'h0, 32'h8765_4321, 2'b00, 2);
    op("p_lo",   1, 1'b0, 3'd2, 32'h0FFC, 32'h0, 32'h0, 2'b10, 2);
    op("p_hi",   1, 1'b0, 3'd2, 32'h1040, 32'h0, 32'h0, 2'b10, 2);
    op("p_lbu",  1, 1'b0, 3'd3, 32'h1013, 32'h0, 32'h0000_0087, 2'b00, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
